// File: rtl/array_sel_sched.sv
// array_sel_sched: round-robin scheduler that lends one shared datapath to
// NREQ requesters. The winner's select code is driven onto dp_select, the
// datapath is given SETTLE cycles to settle, its result is captured and held
// as a response until the consumer takes it.
//
// Optional build macro: ARRAY_SEL_SCHED_STATS_EN
//   defined   -> stat_grants counts accepted requests, saturating at 16'hFFFF
//   undefined -> stat_grants is tied to zero
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no transaction; req_ready offers the round-robin winner
// ST_SETTLE | dp_select applied, down-counter running until capture
// ST_RESP   | response held on rsp_* until rsp_valid && rsp_ready

module array_sel_sched #(
    parameter int NREQ   = 4,
    parameter int SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [32*NREQ-1:0]   req_sel,
    output logic [NREQ-1:0]      req_ready,
    output logic [31:0]          dp_select,
    input  logic                 dp_logic,
    input  logic [7:0]           dp_vec,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [2:0]           rsp_id,
    output logic                 rsp_logic,
    output logic [7:0]           rsp_vec,
    output logic                 busy,
    output logic [15:0]          stat_grants
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Counter is loaded with SETTLE-1 so the capture lands exactly SETTLE
    // edges after the acceptance edge.
    localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);
    localparam logic [3:0] NREQ_W   = 4'(NREQ);
    localparam logic [2:0] LAST_IDX = 3'(NREQ - 1);

    state_t      state_q;
    state_t      state_d;
    logic [2:0]  rr_ptr;
    logic [3:0]  cnt;

    logic [7:0]  valid_pad;
    logic [3:0]  scan_idx;
    logic        win_found;
    logic [2:0]  win_idx;
    logic [31:0] win_sel;
    logic [2:0]  rr_next;

    logic        accept;
    logic        capture;
    logic        rsp_done;

    // Zero-extended copy so the scan can index with a fixed 3-bit pointer.
    assign valid_pad = 8'(req_valid);

    // Round-robin search: first valid requester at or above rr_ptr, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 3'd0;
        scan_idx  = 4'd0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = {1'b0, rr_ptr} + 4'(k);
            if (scan_idx >= NREQ_W) begin
                scan_idx = scan_idx - NREQ_W;
            end
            if (!win_found && valid_pad[scan_idx[2:0]]) begin
                win_found = 1'b1;
                win_idx   = scan_idx[2:0];
            end
        end
    end

    // Mux out the winner's select code.
    always_comb begin
        win_sel = 32'd0;
        for (int k = 0; k < NREQ; k++) begin
            if (3'(k) == win_idx) begin
                win_sel = req_sel[32*k +: 32];
            end
        end
    end

    // One-hot ready, only offered in IDLE and never while reset is asserted.
    always_comb begin
        req_ready = '0;
        for (int k = 0; k < NREQ; k++) begin
            req_ready[k] = (state_q == ST_IDLE) && !rst && win_found &&
                           (3'(k) == win_idx);
        end
    end

    assign accept   = |req_ready;
    assign capture  = (state_q == ST_SETTLE) && (cnt == 4'd0);
    assign rsp_done = (state_q == ST_RESP) && rsp_valid && rsp_ready;
    assign rr_next  = (win_idx == LAST_IDX) ? 3'd0 : win_idx + 3'd1;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and status output.
    always_comb begin
        state_d = state_q;
        busy    = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt == 4'd0) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_valid && rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Grant bookkeeping, settle timer and response capture/hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= 3'd0;
            cnt       <= 4'd0;
            dp_select <= 32'd0;
            rsp_valid <= 1'b0;
            rsp_id    <= 3'd0;
            rsp_logic <= 1'b0;
            rsp_vec   <= 8'd0;
        end else begin
            if (accept) begin
                dp_select <= win_sel;
                rsp_id    <= win_idx;
                rr_ptr    <= rr_next;
                cnt       <= CNT_LOAD;
            end
            if (state_q == ST_SETTLE) begin
                if (capture) begin
                    rsp_logic <= dp_logic;
                    rsp_vec   <= dp_vec;
                    rsp_valid <= 1'b1;
                end else begin
                    cnt <= cnt - 4'd1;
                end
            end
            if (rsp_done) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef ARRAY_SEL_SCHED_STATS_EN
    logic [15:0] grant_cnt;

    // Saturating count of accepted requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt <= 16'd0;
        end else if (accept && (grant_cnt != 16'hFFFF)) begin
            grant_cnt <= grant_cnt + 16'd1;
        end
    end

    assign stat_grants = grant_cnt;
`else
    assign stat_grants = 16'h0000;
`endif

endmodule

// File: tb/tb_array_sel_sched.sv
// Bench for array_sel_sched: table of single transactions with hand-derived
// results, directed multi-cycle sequences, randomized traffic against a
// transaction-level reference model, and a SETTLE=1 instance for throughput.

module tb_array_sel_sched;

    localparam int NREQ   = 4;
    localparam int SETTLE = 2;
`ifdef ARRAY_SEL_SCHED_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [32*NREQ-1:0] req_sel;
    logic [NREQ-1:0]    req_ready;
    logic [31:0]        dp_select;
    logic               dp_logic;
    logic [7:0]         dp_vec;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [2:0]         rsp_id;
    logic               rsp_logic;
    logic [7:0]         rsp_vec;
    logic               busy;
    logic [15:0]        stat_grants;

    logic               s1_rst;
    logic [3:0]         s1_req_valid;
    logic [127:0]       s1_req_sel;
    logic [3:0]         s1_req_ready;
    logic [31:0]        s1_dp_select;
    logic               s1_dp_logic;
    logic [7:0]         s1_dp_vec;
    logic               s1_rsp_valid;
    logic               s1_rsp_ready;
    logic [2:0]         s1_rsp_id;
    logic               s1_rsp_logic;
    logic [7:0]         s1_rsp_vec;
    logic               s1_busy;
    logic [15:0]        s1_stat_grants;

    int checks   = 0;
    int failures = 0;

    array_sel_sched #(.NREQ(NREQ), .SETTLE(SETTLE)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_sel     (req_sel),
        .req_ready   (req_ready),
        .dp_select   (dp_select),
        .dp_logic    (dp_logic),
        .dp_vec      (dp_vec),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_logic   (rsp_logic),
        .rsp_vec     (rsp_vec),
        .busy        (busy),
        .stat_grants (stat_grants)
    );

    array_sel_sched #(.NREQ(4), .SETTLE(1)) u_dut_s1 (
        .clk         (clk),
        .rst         (s1_rst),
        .req_valid   (s1_req_valid),
        .req_sel     (s1_req_sel),
        .req_ready   (s1_req_ready),
        .dp_select   (s1_dp_select),
        .dp_logic    (s1_dp_logic),
        .dp_vec      (s1_dp_vec),
        .rsp_valid   (s1_rsp_valid),
        .rsp_ready   (s1_rsp_ready),
        .rsp_id      (s1_rsp_id),
        .rsp_logic   (s1_rsp_logic),
        .rsp_vec     (s1_rsp_vec),
        .busy        (s1_busy),
        .stat_grants (s1_stat_grants)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_stat(input int n);
        if (!STATS_EN) return 16'h0000;
        return (n > 65535) ? 16'hFFFF : 16'(n);
    endfunction

    function automatic int winner(input logic [NREQ-1:0] rv, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (ptr + k) % NREQ;
            if (rv[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic int oh2i(input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) begin
            if (v[k]) return k;
        end
        return -1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_txn(input logic [NREQ-1:0] rv);
        int n;
        @(negedge clk);
        req_valid = rv;
        rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("txn_rsp_seen", rsp_valid, 1);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  rv;
        logic [7:0]  vec;
        logic        lg;
        logic [3:0]  exp_ready;
        logic [2:0]  exp_id;
        logic [31:0] exp_sel;
    } vec_t;

    vec_t tbl[8];

    // reference model state
    bit          m_inflight;
    bit          m_resp;
    int          m_age;
    int          m_ptr;
    logic [31:0] m_sel;
    int          m_id;
    logic        m_lg;
    logic [7:0]  m_vec;
    int          m_grants;

    initial begin
        int n;
        int ng;
        int g_idx[5];
        int g_cyc[5];
        int na;
        int a_cyc[6];
        int w;
        logic [3:0] exp_rdy;

        tbl[0] = '{4'b0001, 8'h3D, 1'b1, 4'b0001, 3'd0, 32'h0000_0001};
        tbl[1] = '{4'b0001, 8'h5A, 1'b0, 4'b0001, 3'd0, 32'h0000_0001};
        tbl[2] = '{4'b1001, 8'hC3, 1'b1, 4'b1000, 3'd3, 32'h0000_0333};
        tbl[3] = '{4'b1001, 8'h00, 1'b0, 4'b0001, 3'd0, 32'h0000_0001};
        tbl[4] = '{4'b0110, 8'hFF, 1'b1, 4'b0010, 3'd1, 32'h0000_0111};
        tbl[5] = '{4'b0011, 8'h81, 1'b0, 4'b0001, 3'd0, 32'h0000_0001};
        tbl[6] = '{4'b0100, 8'h7E, 1'b1, 4'b0100, 3'd2, 32'h0000_0222};
        tbl[7] = '{4'b1111, 8'h24, 1'b0, 4'b1000, 3'd3, 32'h0000_0333};

        rst          = 1'b1;
        req_valid    = '0;
        req_sel      = {32'h0000_0333, 32'h0000_0222, 32'h0000_0111, 32'h0000_0001};
        dp_logic     = 1'b0;
        dp_vec       = 8'h00;
        rsp_ready    = 1'b0;
        s1_rst       = 1'b1;
        s1_req_valid = '0;
        s1_req_sel   = {32'hD, 32'hC, 32'hB, 32'hA};
        s1_dp_logic  = 1'b1;
        s1_dp_vec    = 8'h5C;
        s1_rsp_ready = 1'b0;

        // reset state, with requests pending to show reset wins
        repeat (2) @(posedge clk);
        @(negedge clk);
        req_valid = 4'hF;
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_dp_select", dp_select, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_logic", rsp_logic, 0);
        chk("rst_rsp_vec", rsp_vec, 0);
        chk("rst_busy", busy, 0);
        chk("rst_stat", stat_grants, 0);
        chk("s1_rst_dp_select", s1_dp_select, 0);
        chk("s1_rst_rsp", {s1_rsp_valid, s1_rsp_logic, s1_rsp_id, s1_rsp_vec}, 0);
        chk("s1_rst_busy", s1_busy, 0);
        chk("s1_rst_stat", s1_stat_grants, 0);
        chk("s1_rst_ready", s1_req_ready, 0);
        req_valid = '0;
        rst       = 1'b0;

        // table of single transactions, round-robin pointer carried across
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            req_valid = tbl[i].rv;
            dp_vec    = tbl[i].vec;
            dp_logic  = tbl[i].lg;
            rsp_ready = 1'b0;
            #1;
            chk($sformatf("tbl%0d_ready", i), req_ready, tbl[i].exp_ready);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("tbl%0d_dp_select", i), dp_select, tbl[i].exp_sel);
            chk($sformatf("tbl%0d_busy", i), busy, 1);
            chk($sformatf("tbl%0d_no_early_rsp", i), rsp_valid, 0);
            req_valid = '0;
            n = 0;
            while (rsp_valid !== 1'b1 && n < 20) begin
                @(posedge clk);
                n++;
                @(negedge clk);
            end
            chk($sformatf("tbl%0d_latency", i), n, SETTLE);
            chk($sformatf("tbl%0d_rsp_id", i), rsp_id, tbl[i].exp_id);
            chk($sformatf("tbl%0d_rsp_vec", i), rsp_vec, tbl[i].vec);
            chk($sformatf("tbl%0d_rsp_logic", i), rsp_logic, tbl[i].lg);
            rsp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("tbl%0d_rsp_clear", i), rsp_valid, 0);
            chk($sformatf("tbl%0d_idle", i), busy, 0);
            rsp_ready = 1'b0;
        end
        chk("tbl_stat", stat_grants, exp_stat(8));

        // response hold while consumer stalls; datapath changes ignored
        @(negedge clk);
        req_valid = 4'b0001;
        dp_vec    = 8'hDA;
        dp_logic  = 1'b1;
        #1;
        chk("hold_ready", req_ready, 4'b0001);
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("hold_rsp_seen", rsp_valid, 1);
        dp_vec    = 8'h11;
        dp_logic  = 1'b0;
        req_valid = 4'hF;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_rsp_vec", rsp_vec, 8'hDA);
            chk("hold_rsp_logic", rsp_logic, 1);
            chk("hold_rsp_valid", rsp_valid, 1);
            chk("hold_rsp_id", rsp_id, 0);
            chk("hold_busy", busy, 1);
            chk("hold_req_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("hold_done_valid", rsp_valid, 0);
        chk("hold_no_accept_on_done", busy, 0);
        #1;
        chk("hold_next_ready", req_ready, 4'b0010);
        req_valid = '0;
        rsp_ready = 1'b0;

        // reset pulse in the middle of SETTLE aborts the transaction
        @(negedge clk);
        req_valid = 4'b0100;
        #1;
        chk("abort_ready", req_ready, 4'b0100);
        @(posedge clk);
        @(negedge clk);
        chk("abort_dp_select", dp_select, 32'h0000_0222);
        chk("abort_busy", busy, 1);
        rst       = 1'b1;
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        #1;
        chk("abort_rst_ready", req_ready, 0);
        @(posedge clk);
        @(negedge clk);
        rst       = 1'b0;
        req_valid = '0;
        chk("abort_busy_after", busy, 0);
        chk("abort_dp_select_after", dp_select, 0);
        chk("abort_stat", stat_grants, 0);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("abort_no_rsp", rsp_valid, 0);
        end
        req_valid = 4'hF;
        #1;
        chk("abort_restart_ready", req_ready, 4'b0001);
        req_valid = '0;
        rsp_ready = 1'b0;

        // statistics after three completed transactions
        run_txn(4'b0001);
        run_txn(4'b0100);
        run_txn(4'b1000);
        chk("stat_three", stat_grants, exp_stat(3));

        // held requests from everyone: strict rotation and period SETTLE+2
        do_reset();
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        ng = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            #1;
            if (req_ready != 0 && ng < 5) begin
                g_idx[ng] = oh2i(req_ready);
                g_cyc[ng] = cyc;
                ng++;
            end
            @(posedge clk);
            @(negedge clk);
        end
        req_valid = '0;
        rsp_ready = 1'b0;
        chk("rr_grant_count", ng, 5);
        for (int k = 0; k < ng; k++) begin
            chk($sformatf("rr_order%0d", k), g_idx[k], k % NREQ);
        end
        for (int k = 1; k < ng; k++) begin
            chk($sformatf("rr_period%0d", k), g_cyc[k] - g_cyc[k-1], SETTLE + 2);
        end

        // randomized traffic against the transaction-level model
        do_reset();
        m_inflight = 0;
        m_resp     = 0;
        m_age      = 0;
        m_ptr      = 0;
        m_sel      = 0;
        m_id       = 0;
        m_lg       = 0;
        m_vec      = 0;
        m_grants   = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            chk("rnd_rsp_valid", rsp_valid, m_resp);
            chk("rnd_busy", busy, m_inflight || m_resp);
            chk("rnd_dp_select", dp_select, m_sel);
            chk("rnd_rsp_id", rsp_id, m_id);
            chk("rnd_rsp_vec", rsp_vec, m_vec);
            chk("rnd_rsp_logic", rsp_logic, m_lg);
            chk("rnd_stat", stat_grants, exp_stat(m_grants));
            rst       = ($urandom_range(0, 39) == 0);
            req_valid = ($urandom_range(0, 3) == 0) ? '0 : 4'($urandom);
            req_sel   = {$urandom, $urandom, $urandom, $urandom};
            dp_vec    = 8'($urandom);
            dp_logic  = 1'($urandom);
            rsp_ready = 1'($urandom);
            #1;
            w = winner(req_valid, m_ptr);
            exp_rdy = (!rst && !m_inflight && !m_resp && w >= 0) ? 4'(1 << w) : 4'b0000;
            chk("rnd_req_ready", req_ready, exp_rdy);
            @(posedge clk);
            if (rst) begin
                m_inflight = 0;
                m_resp     = 0;
                m_ptr      = 0;
                m_sel      = 0;
                m_id       = 0;
                m_lg       = 0;
                m_vec      = 0;
                m_grants   = 0;
            end else if (m_resp) begin
                if (rsp_ready) m_resp = 0;
            end else if (m_inflight) begin
                m_age++;
                if (m_age == SETTLE) begin
                    m_lg       = dp_logic;
                    m_vec      = dp_vec;
                    m_resp     = 1;
                    m_inflight = 0;
                end
            end else if (w >= 0) begin
                m_sel      = req_sel[32*w +: 32];
                m_id       = w;
                m_ptr      = (w + 1) % NREQ;
                m_age      = 0;
                m_inflight = 1;
                m_grants++;
            end
            @(negedge clk);
        end
        rst       = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;

        // SETTLE=1 instance: back-to-back acceptances three cycles apart
        @(negedge clk);
        s1_rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s1_rst       = 1'b0;
        s1_req_valid = 4'hF;
        s1_rsp_ready = 1'b1;
        na = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            #1;
            if (s1_req_ready != 0 && na < 6) begin
                a_cyc[na] = cyc;
                na++;
            end
            @(posedge clk);
            @(negedge clk);
        end
        s1_req_valid = '0;
        s1_rsp_ready = 1'b0;
        chk("s1_accept_count", na, 6);
        for (int k = 1; k < na; k++) begin
            chk($sformatf("s1_period%0d", k), a_cyc[k] - a_cyc[k-1], 3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
